axis_downsizer: RTL and testbench
=================================

Name: axis_downsizer

Overview:
- AXI-stream width down-converter: accepts one wide beat (IN_W bits) and emits it as RATIO = IN_W/OUT_W narrow beats, least-significant slice first.
- Sits on the drain side of fifo_axis instances, feeding narrow consumers (e.g. 64-bit host/DMA paths) from 512-bit internal streams.
- Full throughput: one output beat per cycle while the consumer is ready, with no bubble between consecutive input beats.

Parameters:
- IN_W, 512, input data width; must be an integer multiple of OUT_W.
- OUT_W, 64, output data width; RATIO = IN_W/OUT_W must be >= 2.
- HAS_LAST, "false", "true" carries TLAST across the conversion; "false" ties axis_last_o to 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- axis_data_i  in  IN_W  wide input data.
- axis_valid_i  in  1  input valid.
- axis_last_i  in  1  input last; ignored when HAS_LAST="false".
- axis_ready_o  out  1  input ready.
- axis_data_o  out  OUT_W  narrow output data.
- axis_valid_o  out  1  output valid.
- axis_last_o  out  1  output last.
- axis_ready_i  in  1  output ready.
- busy_o  out  1  holding register occupied (equals axis_valid_o); for drain or idle detection.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates occur on the rising edge of clk.
- State:
  - hold_q[IN_W], last_q, valid_q, idx_q[$clog2(RATIO)].
  - Two-state FSM implied by valid_q: EMPTY (valid_q=0) and SHIFT (valid_q=1).
- Reset: while rst_n=0, the next edge clears valid_q, last_q, idx_q and hold_q. axis_ready_o is forced 0 combinationally while rst_n=0. After release, axis_valid_o=0, axis_last_o=0, axis_data_o=0, busy_o=0, axis_ready_o=1.
- Ready: axis_ready_o = rst_n & (~valid_q | (axis_ready_i & idx_q==RATIO-1)). There is one combinational path from axis_ready_i to axis_ready_o; this is intentional.
- Accept (axis_valid_i & axis_ready_o):
  - hold_q<=axis_data_i; last_q<=axis_last_i (0 if HAS_LAST="false"); idx_q<=0; valid_q<=1.
  - Latency is 1 cycle: slice 0 is visible on the cycle after acceptance.
- Output:
  - axis_valid_o=valid_q.
  - axis_data_o = valid_q ? hold_q[idx_q*OUT_W +: OUT_W] : 0.
  - axis_last_o = valid_q & last_q & (idx_q==RATIO-1).
- Output handshake (valid_q & axis_ready_i):
  - If idx_q<RATIO-1, idx_q increments.
  - If idx_q==RATIO-1 and no simultaneous accept, valid_q<=0 (SHIFT->EMPTY).
  - If idx_q==RATIO-1 and a simultaneous accept occurs, the accept wins: reload and idx_q<=0, staying in SHIFT. This gives zero-bubble back-to-back operation.
- Stall: while valid_q & ~axis_ready_i, axis_data_o and axis_last_o stay stable. No input is accepted in this state, since axis_ready_o=0.
- axis_valid_o never depends combinationally on axis_ready_i.
- Upstream valid that drops before acceptance is not captured.
- Reset mid-beat: remaining slices are discarded; no partial beat is emitted after reset.
- Elaboration: $error if IN_W%OUT_W != 0 or RATIO<2.

Test Plan:
- Single beat, IN_W=32, OUT_W=8, HAS_LAST="true": input 0xDDCCBBAA with last=1, ready_i held 1 -> outputs AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; last=1 only on DD; ready_o=0 for cycles 2-4, back to 1 on the DD cycle.
- Back-to-back: inputs 0x44332211 then 0x88776655 (no last), valid_i and ready_i held 1 -> 8 contiguous output beats 11..88, no bubble; second input accepted on the same cycle 44 is consumed; last never asserted.
- Backpressure: ready_i toggles 1,0,0,1,... during 0xDDCCBBAA -> each slice held stable while ready_i=0; exactly 4 output handshakes, in order AA..DD; ready_o stays 0 until the DD handshake.
- Reset mid-beat: assert rst_n=0 after slice BB is consumed -> next cycle valid_o=0, data_o=0, last_o=0; CC and DD are never emitted; after release ready_o=1 and a new beat converts correctly.
- HAS_LAST="false": drive axis_last_i=1 on every input -> axis_last_o stays 0 throughout; data slices unchanged.
- Default config (512->64): random data, random valid/ready, 1000 beats -> scoreboard reassembly matches input exactly; no beat loss or duplication; busy_o==axis_valid_o every cycle.

Source files
------------

// File: rtl/axis_downsizer_if.sv
// Wide-in / narrow-out stream bundle for axis_downsizer.
// The slave modport is the converter's view; master is the surrounding logic.
interface axis_downsizer_if #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned OUT_W = 64
);
  logic [IN_W-1:0]  axis_data_i;
  logic             axis_valid_i;
  logic             axis_last_i;
  logic             axis_ready_o;
  logic [OUT_W-1:0] axis_data_o;
  logic             axis_valid_o;
  logic             axis_last_o;
  logic             axis_ready_i;
  logic             busy_o;

  modport slave (
    input  axis_data_i, axis_valid_i, axis_last_i, axis_ready_i,
    output axis_ready_o, axis_data_o, axis_valid_o, axis_last_o, busy_o
  );

  modport master (
    output axis_data_i, axis_valid_i, axis_last_i, axis_ready_i,
    input  axis_ready_o, axis_data_o, axis_valid_o, axis_last_o, busy_o
  );
endinterface

// File: rtl/axis_downsizer.sv
// AXI-stream width down-converter: one IN_W beat becomes IN_W/OUT_W OUT_W beats,
// least-significant slice first, with no bubble between consecutive wide beats.
module axis_downsizer #(
  parameter int unsigned IN_W     = 512,
  parameter int unsigned OUT_W    = 64,
  parameter string       HAS_LAST = "false"
) (
  input logic             clk,
  input logic             rst_n,
  axis_downsizer_if.slave bus_io
);

  localparam int unsigned     Ratio   = IN_W / OUT_W;
  localparam int unsigned     IdxW    = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam bit              UseLast = (HAS_LAST == "true");
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(Ratio - 1);

  if (((IN_W % OUT_W) != 0) || (Ratio < 2)) begin : gen_param_check
    $error("axis_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  typedef enum logic {StEmpty, StShift} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] hold_q, hold_d;
  logic            last_q, last_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic valid;
  logic last_slice;
  logic in_ready;
  logic accept;
  logic out_fire;

  assign valid      = (state_q == StShift);
  assign last_slice = (idx_q == IdxMax);
  // Refill is allowed in the same cycle the final slice leaves, hence the
  // combinational path from axis_ready_i.
  assign in_ready   = rst_n & (~valid | (bus_io.axis_ready_i & last_slice));
  assign accept     = bus_io.axis_valid_i & in_ready;
  assign out_fire   = valid & bus_io.axis_ready_i;

  // Next-state: advance the slice index on output handshakes; an accept always
  // wins over the SHIFT->EMPTY transition so back-to-back beats stay contiguous.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (out_fire) begin
      if (!last_slice) begin
        idx_d = idx_q + 1'b1;
      end else begin
        state_d = StEmpty;
      end
    end
    if (accept) begin
      state_d = StShift;
      hold_d  = bus_io.axis_data_i;
      last_d  = UseLast ? bus_io.axis_last_i : 1'b0;
      idx_d   = '0;
    end
  end

  // State registers with synchronous active-low reset; reset drops any partial beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are decoded from registered state only (plus the ready path above).
  always_comb begin
    bus_io.axis_ready_o = in_ready;
    bus_io.axis_valid_o = valid;
    bus_io.busy_o       = valid;
    bus_io.axis_last_o  = valid & last_q & last_slice;
    bus_io.axis_data_o  = valid ? hold_q[idx_q*OUT_W +: OUT_W] : '0;
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Scoreboard bench for axis_downsizer: three instances (32->8 with last,
// 32->8 without last, default 512->64) each checked by its own monitor.
module tb_axis_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  axis_downsizer_if #(.IN_W(32), .OUT_W(8)) if_a ();
  axis_downsizer_if #(.IN_W(32), .OUT_W(8)) if_b ();
  axis_downsizer_if                         if_c ();

  axis_downsizer #(.IN_W(32), .OUT_W(8), .HAS_LAST("true")) u_a (
    .clk(clk), .rst_n(rst_a), .bus_io(if_a.slave)
  );
  axis_downsizer #(.IN_W(32), .OUT_W(8), .HAS_LAST("false")) u_b (
    .clk(clk), .rst_n(rst_b), .bus_io(if_b.slave)
  );
  axis_downsizer u_c (
    .clk(clk), .rst_n(rst_c), .bus_io(if_c.slave)
  );

  int total = 0;
  int bad   = 0;

  // Expected beats: {last, data} for the 8-bit instances, data for the 64-bit one.
  logic [8:0]  qa[$];
  logic [8:0]  qb[$];
  logic [63:0] qc[$];

  bit c_run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic extra_beat(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got beat %0h expected no beat at %0t", name, act, $time);
  endtask

  task automatic send_a(input logic [31:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    if_a.axis_data_i  = d;
    if_a.axis_last_i  = l;
    if_a.axis_valid_i = 1'b1;
    @(negedge clk);
    while (!if_a.axis_ready_o && n < 1000) begin n++; @(negedge clk); end
    if (n >= 1000) chk("a_accept_timeout", 64'(if_a.axis_ready_o), 64'd1);
    @(posedge clk); #1;
    if_a.axis_valid_i = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    if_b.axis_data_i  = d;
    if_b.axis_last_i  = l;
    if_b.axis_valid_i = 1'b1;
    @(negedge clk);
    while (!if_b.axis_ready_o && n < 1000) begin n++; @(negedge clk); end
    if (n >= 1000) chk("b_accept_timeout", 64'(if_b.axis_ready_o), 64'd1);
    @(posedge clk); #1;
    if_b.axis_valid_i = 1'b0;
  endtask

  task automatic send_c(input logic [511:0] d);
    int n = 0;
    @(posedge clk); #1;
    if_c.axis_data_i  = d;
    if_c.axis_valid_i = 1'b1;
    @(negedge clk);
    while (!if_c.axis_ready_o && n < 1000) begin n++; @(negedge clk); end
    if (n >= 1000) chk("c_accept_timeout", 64'(if_c.axis_ready_o), 64'd1);
    @(posedge clk); #1;
    if_c.axis_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 40000) begin
      n++;
      @(negedge clk);
    end
    chk(name, 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor A: pops on each output handshake and checks that a stalled slice holds.
  logic       a_stall = 1'b0;
  logic [9:0] a_snap  = '0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (a_stall)
      chk("a_stall_hold", 64'({if_a.axis_valid_o, if_a.axis_last_o, if_a.axis_data_o}),
          64'(a_snap));
    a_stall = if_a.axis_valid_o & ~if_a.axis_ready_i & rst_a;
    a_snap  = {if_a.axis_valid_o, if_a.axis_last_o, if_a.axis_data_o};
    if (if_a.axis_valid_o && if_a.axis_ready_i) begin
      if (qa.size() == 0) begin
        extra_beat("a_unexpected_beat", 64'({if_a.axis_last_o, if_a.axis_data_o}));
      end else begin
        e = qa.pop_front();
        chk("a_beat", 64'({if_a.axis_last_o, if_a.axis_data_o}), 64'(e));
      end
    end
  end

  // Monitor B: last must never appear on the output.
  always @(negedge clk) begin
    logic [8:0] e;
    if (if_b.axis_valid_o) chk("b_last_tied_low", 64'(if_b.axis_last_o), 64'd0);
    if (if_b.axis_valid_o && if_b.axis_ready_i) begin
      if (qb.size() == 0) begin
        extra_beat("b_unexpected_beat", 64'(if_b.axis_data_o));
      end else begin
        e = qb.pop_front();
        chk("b_beat", 64'({if_b.axis_last_o, if_b.axis_data_o}), 64'(e));
      end
    end
  end

  // Monitor C: reassembly order plus busy/valid agreement every cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_c) chk("c_busy_eq_valid", 64'(if_c.busy_o), 64'(if_c.axis_valid_o));
    if (if_c.axis_valid_o && if_c.axis_ready_i) begin
      if (qc.size() == 0) begin
        extra_beat("c_unexpected_beat", if_c.axis_data_o);
      end else begin
        e = qc.pop_front();
        chk("c_beat", if_c.axis_data_o, e);
        chk("c_last_low", 64'(if_c.axis_last_o), 64'd0);
      end
    end
  end

  // Random output backpressure for the wide instance.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (c_run) if_c.axis_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0]   pat;
    logic [511:0] d;
    int           cnt;
    int           k;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.axis_data_i = '0; if_a.axis_valid_i = 1'b0; if_a.axis_last_i = 1'b0;
    if_a.axis_ready_i = 1'b1;
    if_b.axis_data_i = '0; if_b.axis_valid_i = 1'b0; if_b.axis_last_i = 1'b0;
    if_b.axis_ready_i = 1'b1;
    if_c.axis_data_i = '0; if_c.axis_valid_i = 1'b0; if_c.axis_last_i = 1'b0;
    if_c.axis_ready_i = 1'b1;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ready_forced_low", 64'(if_a.axis_ready_o), 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    chk("reset_valid_o", 64'(if_a.axis_valid_o), 64'd0);
    chk("reset_last_o",  64'(if_a.axis_last_o),  64'd0);
    chk("reset_data_o",  64'(if_a.axis_data_o),  64'd0);
    chk("reset_busy_o",  64'(if_a.busy_o),       64'd0);
    chk("reset_ready_o", 64'(if_a.axis_ready_o), 64'd1);
    chk("reset_c_ready_o", 64'(if_c.axis_ready_o), 64'd1);

    // Single beat with last; ready_o low until the final slice is on the bus.
    qa.push_back({1'b0, 8'hAA}); qa.push_back({1'b0, 8'hBB});
    qa.push_back({1'b0, 8'hCC}); qa.push_back({1'b1, 8'hDD});
    send_a(32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_valid_o", 64'(if_a.axis_valid_o), 64'd1);
      chk("single_ready_o", 64'(if_a.axis_ready_o), (i == 3) ? 64'd1 : 64'd0);
    end
    drain("single_drain");

    // Back-to-back: eight contiguous slices, refill while 44 is on the bus.
    qa.push_back({1'b0, 8'h11}); qa.push_back({1'b0, 8'h22});
    qa.push_back({1'b0, 8'h33}); qa.push_back({1'b0, 8'h44});
    qa.push_back({1'b0, 8'h55}); qa.push_back({1'b0, 8'h66});
    qa.push_back({1'b0, 8'h77}); qa.push_back({1'b0, 8'h88});
    send_a(32'h44332211, 1'b0);
    fork
      send_a(32'h88776655, 1'b0);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("b2b_no_bubble", 64'(if_a.axis_valid_o), 64'd1);
          if (i == 3) chk("b2b_refill_ready", 64'(if_a.axis_ready_o), 64'd1);
        end
      end
    join
    drain("b2b_drain");

    // Backpressure: ready pattern 1,0,0,1 repeating.
    qa.push_back({1'b0, 8'hAA}); qa.push_back({1'b0, 8'hBB});
    qa.push_back({1'b0, 8'hCC}); qa.push_back({1'b1, 8'hDD});
    send_a(32'hDDCCBBAA, 1'b1);
    pat = 4'b1001;
    cnt = 0;
    k   = 0;
    while (cnt < 4 && k < 100) begin
      if_a.axis_ready_i = pat[k % 4];
      @(negedge clk);
      chk("bp_valid_o", 64'(if_a.axis_valid_o), 64'd1);
      chk("bp_ready_o", 64'(if_a.axis_ready_o),
          (if_a.axis_ready_i && cnt == 3) ? 64'd1 : 64'd0);
      if (if_a.axis_ready_i) cnt++;
      @(posedge clk); #1;
      k++;
    end
    chk("bp_handshakes", 64'(cnt), 64'd4);
    if_a.axis_ready_i = 1'b1;
    drain("bp_drain");

    // Reset asserted while BB is presented: CC and DD must never appear.
    qa.push_back({1'b0, 8'hAA}); qa.push_back({1'b0, 8'hBB});
    send_a(32'hDDCCBBAA, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_low", 64'(if_a.axis_ready_o), 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid_o", 64'(if_a.axis_valid_o), 64'd0);
    chk("rst_mid_data_o",  64'(if_a.axis_data_o),  64'd0);
    chk("rst_mid_last_o",  64'(if_a.axis_last_o),  64'd0);
    chk("rst_mid_ready_o", 64'(if_a.axis_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", 64'(if_a.axis_valid_o), 64'd0);
    qa.push_back({1'b0, 8'h01}); qa.push_back({1'b0, 8'h02});
    qa.push_back({1'b0, 8'h03}); qa.push_back({1'b1, 8'h04});
    send_a(32'h04030201, 1'b1);
    drain("rst_mid_drain");

    // Last disabled: input last is ignored, data unchanged.
    qb.push_back({1'b0, 8'hAA}); qb.push_back({1'b0, 8'hBB});
    qb.push_back({1'b0, 8'hCC}); qb.push_back({1'b0, 8'hDD});
    qb.push_back({1'b0, 8'h21}); qb.push_back({1'b0, 8'h43});
    qb.push_back({1'b0, 8'h65}); qb.push_back({1'b0, 8'h87});
    send_b(32'hDDCCBBAA, 1'b1);
    send_b(32'h87654321, 1'b1);
    drain("nolast_drain");

    // Default 512->64 with random data, input gaps and output backpressure.
    c_run = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
      for (int j = 0; j < 8; j++) qc.push_back(d[64*j +: 64]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_c(d);
    end
    drain("random_drain");
    c_run = 1'b0;
    if_c.axis_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("random_idle", 64'(if_c.axis_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
